// File: rtl/uart_pkg.sv
// Shared UART loopback types and constants: transmit-queue FSM states and the
// CR/LF character codes used by the optional line-ending expansion.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    LF   = 2'd2
  } uart_tx_queue_state_e;

  localparam int unsigned uart_cr_gp = 32'h0000_000D;
  localparam int unsigned uart_lf_gp = 32'h0000_000A;

endpackage

// File: rtl/uart_fifo.sv
// Circular FIFO with naturally wrapping read/write pointers and an occupancy
// counter. A push into a full queue is accepted only when a pop happens in the same cycle.
module uart_fifo #(
  parameter int unsigned width_p = 8,
  parameter int unsigned els_p   = 16,
  localparam int unsigned ptr_w_lp = $clog2(els_p),
  localparam int unsigned cnt_w_lp = $clog2(els_p + 1)
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                push_i,
  input  logic [width_p-1:0]  data_i,
  input  logic                pop_i,
  output logic [width_p-1:0]  data_o,
  output logic                push_ok_o,
  output logic                empty_o,
  output logic [cnt_w_lp-1:0] count_o
);

  logic [width_p-1:0]  mem_q [els_p];
  logic [ptr_w_lp-1:0] wptr_q, wptr_d;
  logic [ptr_w_lp-1:0] rptr_q, rptr_d;
  logic [cnt_w_lp-1:0] count_q, count_d;
  logic                full;
  logic                pop_ok;
  logic                push_ok;

  assign full    = (count_q == cnt_w_lp'(els_p));
  assign empty_o = (count_q == '0);
  assign pop_ok  = pop_i && !empty_o;
  // A simultaneous pop frees the slot this push needs.
  assign push_ok = push_i && (!full || pop_ok);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_ok) wptr_d = wptr_q + ptr_w_lp'(1);
    if (pop_ok)  rptr_d = rptr_q + ptr_w_lp'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + cnt_w_lp'(1);
      2'b01:   count_d = count_q - cnt_w_lp'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q] <= data_i;
  end

  assign data_o    = mem_q[rptr_q];
  assign push_ok_o = push_ok;
  assign count_o   = count_q;

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue between uart_rx and uart_tx: buffers received characters and issues
// one frame at a time. Define UART_TX_QUEUE_CRLF_EN to follow every CR with a generated LF.
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int unsigned data_bits_p = 8,
  parameter int unsigned els_p       = 16
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          in_v_i,
  input  logic [data_bits_p-1:0]        in_data_i,
  output logic                          tx_v_o,
  output logic [data_bits_p-1:0]        tx_data_o,
  input  logic                          tx_done_i,
  output logic [$clog2(els_p+1)-1:0]    count_o,
  output logic                          overflow_o
);

  uart_tx_queue_state_e   state_q, state_d;
  logic                   tx_v_q, tx_v_d;
  logic [data_bits_p-1:0] tx_data_q, tx_data_d;
  logic                   overflow_q, overflow_d;
  logic                   pop;
  logic                   issue;
  logic                   push_ok;
  logic                   empty;
  logic                   lf_pending;
  logic [data_bits_p-1:0] head;

  uart_fifo #(
    .width_p (data_bits_p),
    .els_p   (els_p)
  ) fifo (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .push_i    (in_v_i),
    .data_i    (in_data_i),
    .pop_i     (pop),
    .data_o    (head),
    .push_ok_o (push_ok),
    .empty_o   (empty),
    .count_o   (count_o)
  );

`ifdef UART_TX_QUEUE_CRLF_EN
  logic cr_q, cr_d;
  assign lf_pending = cr_q;
`else
  assign lf_pending = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    tx_v_d    = 1'b0;
    tx_data_d = tx_data_q;
    pop       = 1'b0;
    issue     = 1'b0;
`ifdef UART_TX_QUEUE_CRLF_EN
    cr_d      = cr_q;
`endif
    case (state_q)
      IDLE: issue = !empty;
      BUSY: begin
        if (tx_done_i) begin
          if (lf_pending)  state_d = LF;
          else if (!empty) issue   = 1'b1;
          else             state_d = IDLE;
        end
      end
      LF: begin
`ifdef UART_TX_QUEUE_CRLF_EN
        tx_v_d    = 1'b1;
        tx_data_d = data_bits_p'(uart_lf_gp);
        cr_d      = 1'b0;
        state_d   = BUSY;
`else
        state_d   = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase

    // Head of queue goes straight to the output register; no bypass from the push side.
    if (issue) begin
      pop       = 1'b1;
      tx_v_d    = 1'b1;
      tx_data_d = head;
      state_d   = BUSY;
`ifdef UART_TX_QUEUE_CRLF_EN
      cr_d      = (head == data_bits_p'(uart_cr_gp));
`endif
    end
  end

  assign overflow_d = overflow_q || (in_v_i && !push_ok);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      tx_v_q     <= 1'b0;
      tx_data_q  <= '0;
      overflow_q <= 1'b0;
`ifdef UART_TX_QUEUE_CRLF_EN
      cr_q       <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      tx_v_q     <= tx_v_d;
      tx_data_q  <= tx_data_d;
      overflow_q <= overflow_d;
`ifdef UART_TX_QUEUE_CRLF_EN
      cr_q       <= cr_d;
`endif
    end
  end

  assign tx_v_o     = tx_v_q;
  assign tx_data_o  = tx_data_q;
  assign overflow_o = overflow_q;

endmodule
